uart_tx_buffered: RTL and testbench

UART transmitter with a small transmit FIFO, the send-side counterpart of the CPU's UART receive path. Software (via the peripheral bus) writes bytes; the block serialises each as an 8N1 frame (start bit, 8 data bits LSB first, one stop bit) on UART_TX. It runs from the system clock, with no separate baud clock, using an internal bit-period counter.

---
 rtl/uart_tx_buffered_pkg.sv | 21 ++
 rtl/uart_tx_buffered_if.sv | 27 ++
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx_buffered.sv | 135 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions: FSM encodings, frame geometry, baud defaults.
// The receive path pulls its oversampling constants from here as well.
package uart_tx_buffered_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int UART_DATA_BITS   = 8;
   localparam int DEF_CLKS_PER_BIT = 10417;
   localparam int RX_OVERSAMPLE    = 16;
   localparam int RX_MID_SAMPLE    = RX_OVERSAMPLE / 2;

   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Peripheral-bus side of the buffered UART transmitter.
// Master is the bus writer, slave is the transmitter.
interface uart_tx_buffered_if;
   import uart_tx_buffered_pkg::*;

   logic [UART_DATA_BITS-1:0] TX_DATA;
   logic                      TX_EN;
   logic                      UART_TX;
   logic                      TX_FULL;
   logic                      TX_EMPTY;
   logic                      TX_BUSY;
   logic                      TX_DONE;
   logic                      TX_DROP;

   modport master (
      output TX_DATA, TX_EN,
      input  UART_TX, TX_FULL, TX_EMPTY,
      input  TX_BUSY, TX_DONE, TX_DROP
   );

   modport slave (
      input  TX_DATA, TX_EN,
      output UART_TX, TX_FULL, TX_EMPTY,
      output TX_BUSY, TX_DONE, TX_DROP
   );

endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO; pushes are refused while full, even on a same-cycle pop.
// Power-of-two depth so the pointers wrap for free.
module uart_tx_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [W-1:0]               i_data,
   output logic [W-1:0]               o_head,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (w_pop && !w_push)
            r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= i_data;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a small FIFO, timed by a bit-period counter.
// Queued bytes are sent back to back with no idle gap between frames.
module uart_tx_buffered
   import uart_tx_buffered_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input logic               clk,
   input logic               reset,
   uart_tx_buffered_if.slave bus
);

   localparam int CW = cnt_width(CLKS_PER_BIT);
   localparam int QW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

   tx_state_t                 r_state;
   tx_state_t                 w_state;
   logic [CW-1:0]             r_cnt;
   logic [CW-1:0]             w_cnt;
   logic [2:0]                r_idx;
   logic [2:0]                w_idx;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic [UART_DATA_BITS-1:0] w_shift;
   logic                      r_tx;
   logic                      w_tx;
   logic                      r_drop;
   logic                      w_pop;
   logic                      w_bit_end;
   logic                      w_has;
   logic [UART_DATA_BITS-1:0] w_head;
   logic                      w_full;
   logic                      w_empty;
   logic [QW-1:0]             w_count;

   uart_tx_fifo #(
      .W     (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (bus.TX_EN),
      .i_pop   (w_pop),
      .i_data  (bus.TX_DATA),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign w_has     = (w_count != '0);
   assign w_bit_end = (r_cnt == LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_idx   <= w_idx;
         r_shift <= w_shift;
         r_tx    <= w_tx;
         r_drop  <= bus.TX_EN && w_full;
      end
   end

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_idx   = r_idx;
      w_shift = r_shift;
      w_pop   = 1'b0;
      w_tx    = 1'b1;
      if (r_state != IDLE)
         w_cnt = w_bit_end ? '0 : r_cnt + 1'b1;
      unique case (r_state)
         IDLE: begin
            if (w_has) begin
               w_pop   = 1'b1;
               w_shift = w_head;
               w_cnt   = '0;
               w_state = START;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_idx   = '0;
               w_state = DATA;
            end
         end
         DATA: begin
            if (w_bit_end) begin
               w_shift = r_shift >> 1;
               w_idx   = r_idx + 3'd1;
               if (r_idx == LAST_BIT)
                  w_state = STOP;
            end
         end
         STOP: begin
            // chain straight into the next start bit when data waits
            if (w_bit_end) begin
               if (w_has) begin
                  w_pop   = 1'b1;
                  w_shift = w_head;
                  w_state = START;
               end else begin
                  w_state = IDLE;
               end
            end
         end
         default: w_state = IDLE;
      endcase
      // line level follows the state being entered, so it is registered
      unique case (w_state)
         START:   w_tx = 1'b0;
         DATA:    w_tx = w_shift[0];
         default: w_tx = 1'b1;
      endcase
   end

   assign bus.UART_TX  = r_tx;
   assign bus.TX_FULL  = w_full;
   assign bus.TX_EMPTY = w_empty;
   assign bus.TX_BUSY  = (r_state != IDLE);
   assign bus.TX_DONE  = (r_state == STOP) && w_bit_end;
   assign bus.TX_DROP  = r_drop;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a line monitor decodes frames and
// compares them against the bytes the stimulus expects to be sent.
module tb_uart_tx_buffered;

   localparam int CPB   = 16;
   localparam int FRAME = 10 * CPB;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_pass;
   int   cyc;

   uart_tx_buffered_if bus();

   uart_tx_buffered #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   logic [7:0] sb[$];
   bit         in_frame;
   bit         gap;
   int         k;
   logic [7:0] rx_byte;
   int         n_done;
   int         n_gapless;
   int         last_done;
   int         prev_done;

   always @(negedge clk) begin
      if (!reset) begin
         in_frame = 1'b0;
         k = 0;
      end else begin
         gap = 1'b0;
         if (in_frame) begin
            k++;
            if (k == CPB / 2)
               chk("start_bit", bus.UART_TX, 1'b0);
            if (k >= 24 && k < 152 && (k % CPB) == 8)
               rx_byte[(k - 24) / CPB] = bus.UART_TX;
            if (k == 152)
               chk("stop_bit", bus.UART_TX, 1'b1);
            if (k == FRAME - 1)
               chk("done_at_end", bus.TX_DONE, 1'b1);
            if (k == FRAME) begin
               in_frame = 1'b0;
               gap = 1'b1;
               if (sb.size() == 0)
                  chk("sb_underflow", rx_byte, 32'hdead);
               else
                  chk("byte", rx_byte, sb.pop_front());
            end
         end
         if (bus.TX_DONE && !(in_frame && k == FRAME - 1))
            chk("stray_done", 1'b1, 1'b0);
         if (bus.TX_DONE) begin
            prev_done = last_done;
            last_done = cyc;
            n_done++;
         end
         if (!in_frame && bus.UART_TX == 1'b0) begin
            in_frame = 1'b1;
            k = 0;
            if (gap)
               n_gapless++;
         end
      end
   end

   task automatic put(input logic [7:0] d, input bit acc);
      bus.TX_DATA = d;
      bus.TX_EN   = 1'b1;
      if (acc)
         sb.push_back(d);
      @(negedge clk);
      chk("drop", bus.TX_DROP, !acc);
      bus.TX_EN = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int i;
      i = 0;
      while ((in_frame || !bus.TX_EMPTY || bus.TX_BUSY) && i < lim) begin
         @(negedge clk);
         i++;
      end
      if (i >= lim)
         chk("idle_timeout", 1'b0, 1'b1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      int t_e1;
      int d0;
      int g0;
      int i;
      n_chk = 0;
      n_pass = 0;
      cyc = 0;
      n_done = 0;
      n_gapless = 0;
      last_done = 0;
      prev_done = 0;
      bus.TX_DATA = 8'h00;
      bus.TX_EN = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx", bus.UART_TX, 1'b1);
      chk("rst_empty", bus.TX_EMPTY, 1'b1);
      chk("rst_full", bus.TX_FULL, 1'b0);
      chk("rst_busy", bus.TX_BUSY, 1'b0);
      chk("rst_drop", bus.TX_DROP, 1'b0);
      reset = 1'b1;
      repeat (200) @(negedge clk);
      chk("quiet_done", n_done, 0);
      chk("quiet_tx", bus.UART_TX, 1'b1);
      chk("quiet_busy", bus.TX_BUSY, 1'b0);

      put(8'hA5, 1'b1);
      chk("e0_empty", bus.TX_EMPTY, 1'b0);
      chk("e0_tx", bus.UART_TX, 1'b1);
      @(negedge clk);
      t_e1 = cyc;
      chk("e1_tx", bus.UART_TX, 1'b0);
      chk("e1_empty", bus.TX_EMPTY, 1'b1);
      chk("e1_busy", bus.TX_BUSY, 1'b1);
      d0 = n_done;
      wait_idle(1000);
      chk("single_done_n", n_done - d0, 1);
      chk("single_done_t", last_done - t_e1, FRAME - 1);
      chk("single_busy", bus.TX_BUSY, 1'b0);

      d0 = n_done;
      g0 = n_gapless;
      put(8'h55, 1'b1);
      put(8'h0F, 1'b1);
      wait_idle(2000);
      chk("b2b_done_n", n_done - d0, 2);
      chk("b2b_spacing", last_done - prev_done, FRAME);
      chk("b2b_gapless", n_gapless - g0, 1);

      for (int b = 1; b <= 5; b++)
         put(8'(b), 1'b1);
      chk("ovf_full", bus.TX_FULL, 1'b1);
      put(8'h06, 1'b0);
      chk("ovf_full2", bus.TX_FULL, 1'b1);
      i = 0;
      while (!bus.TX_DONE && i < 400) begin
         @(negedge clk);
         i++;
      end
      chk("col_done_seen", bus.TX_DONE, 1'b1);
      put(8'h77, 1'b0);
      chk("col_full_drop", bus.TX_FULL, 1'b0);
      chk("col_next_start", bus.UART_TX, 1'b0);
      wait_idle(5000);

      put(8'hFF, 1'b1);
      i = 0;
      while (!(in_frame && k >= 70) && i < 300) begin
         @(negedge clk);
         i++;
      end
      chk("mid_reached", in_frame, 1'b1);
      reset = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("mid_tx", bus.UART_TX, 1'b1);
      chk("mid_busy", bus.TX_BUSY, 1'b0);
      chk("mid_empty", bus.TX_EMPTY, 1'b1);
      reset = 1'b1;
      d0 = n_done;
      repeat (200) @(negedge clk);
      chk("mid_no_done", n_done - d0, 0);
      chk("mid_tx_idle", bus.UART_TX, 1'b1);

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
